framebuffer_arbiter: RTL
========================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, pixel address width per bank ({row[3:0], column[5:0]}).
REQ-002 Parameter DATA_WIDTH, default 18, pixel width (R/G/B, 6 brightness bits each).
REQ-003 clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 scan_req  input  1  scan side requests one pixel read this cycle.
REQ-006 scan_addr  input  ADDR_WIDTH  pixel address of scan read.
REQ-007 scan_valid  output  1  scan_data valid; single-cycle strobe.
REQ-008 scan_data  output  DATA_WIDTH  pixel read from display bank.
REQ-009 host_wr_valid  input  1  host write pending.
REQ-010 host_wr_addr  input  ADDR_WIDTH  host write address in back bank.
REQ-011 host_wr_data  input  DATA_WIDTH  host write data.
REQ-012 host_wr_ready  output  1  write accepted when valid && ready.
REQ-013 swap_req  input  1  pulse: host finished back frame, request bank swap.
REQ-014 frame_start  input  1  pulse at scan frame boundary (row 0, before first read).
REQ-015 swap_done  output  1  one-cycle pulse, cycle after bank toggles.
REQ-016 display_bank  output  1  bank currently scanned.
REQ-017 ram_addr  output  ADDR_WIDTH+1  {bank, address} to single-port RAM.
REQ-018 ram_we  output  1  RAM write strobe.
REQ-019 ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-020 ram_rdata  input  DATA_WIDTH  RAM read data, 1-cycle latency after address.

Function
REQ-021 RAM port driven combinationally from grant: exactly one of scan read, host write, or idle per cycle.
REQ-022 Scan has absolute priority: scan_req=1 -> ram_addr={display_bank, scan_addr}, ram_we=0, host_wr_ready=0.
REQ-023 scan_valid asserts exactly one cycle after each scan_req; scan_data=ram_rdata in that cycle; latency fixed, never stalled.
REQ-024 Bank used for a scan read is the display_bank of the request cycle, even if swap occurs that cycle.
REQ-025 host_wr_ready = !scan_req && state==IDLE; on handshake ram_addr={~display_bank, host_wr_addr}, ram_we=1, ram_wdata=host_wr_data.
REQ-026 Idle cycles: ram_we=0, ram_addr held at last value.
REQ-027 Swap FSM states IDLE, PENDING, SWAP.
REQ-028 IDLE: swap_req -> PENDING; host writes allowed.
REQ-029 PENDING: host_wr_ready=0; frame_start -> SWAP; swap_req ignored.
REQ-030 SWAP: display_bank toggles at end of cycle; -> IDLE; swap_done=1 next cycle.
REQ-031 swap_req and frame_start same cycle in IDLE: enter PENDING only; swap waits for next frame_start (no tearing).
REQ-032 frame_start in IDLE: no effect.
REQ-033 swap_req while in SWAP: ignored; host must re-request after swap_done.
REQ-034 Scan reads continue unaffected in all FSM states.

Reset
REQ-035 Reset values: state=IDLE, display_bank=0, scan_valid=0, swap_done=0, ram_we=0, ram_addr=0.
REQ-036 Reset mid-swap or mid-read: pending swap and in-flight scan_valid discarded; no write issued that cycle.
REQ-037 host_wr_ready=0 while reset asserted.

Structure
REQ-038 Shared package holds ADDR_WIDTH, DATA_WIDTH defaults and FSM state encoding (IDLE=0, PENDING=1, SWAP=2).
REQ-039 Single flat module; RAM is external, no sub-module.

Verification
REQ-040 scan_req=1 addr 0x0A5 with host_wr_valid=1 -> ram_addr=0x0A5 (bank 0), host_wr_ready=0; next cycle scan_valid=1, scan_data=RAM[0x0A5].
REQ-041 Host writes 0x3FFFF to 0x010 with scan idle -> ram_we=1, ram_addr=0x410 (back bank 1), ready=1.
REQ-042 swap_req, 5 cycles, frame_start -> host_wr_ready=0 for those cycles, display_bank=1 two cycles after frame_start, swap_done pulses once.
REQ-043 swap_req and frame_start same cycle -> no toggle; toggle only on following frame_start.
REQ-044 scan_req in SWAP cycle -> read uses old bank; following read uses new bank.
REQ-045 Reset asserted while PENDING -> state IDLE, display_bank=0, no swap_done.

Source files
------------

// File: rtl/framebuffer_arbiter_pkg.sv
// Shared definitions for the double-buffered framebuffer arbiter.
//   FB_ADDR_WIDTH / FB_DATA_WIDTH : default pixel address / pixel width
//   ST_IDLE / ST_PENDING / ST_SWAP : swap FSM state encoding
//   grant_e                        : owner of the RAM port in a given cycle
package framebuffer_arbiter_pkg;

  localparam int FB_ADDR_WIDTH = 10;  // {row[3:0], column[5:0]}
  localparam int FB_DATA_WIDTH = 18;  // R/G/B, 6 bits each

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SWAP    = 2'd2;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_SCAN = 2'd1,
    GRANT_HOST = 2'd2
  } grant_e;

endpackage

// File: rtl/framebuffer_arbiter.sv
// Double-buffered framebuffer arbiter for a single-port external RAM.
// The scan side reads the display bank with absolute priority; the host
// writes into the back bank when the scan side is silent and no swap is in
// progress. A swap request is parked until the next frame boundary so the
// scanned image never tears.
//
// Ports:
//   clk_in, reset                 : clock, synchronous active-high reset
//   scan_req/scan_addr            : one pixel read per request cycle
//   scan_valid/scan_data          : read result, exactly one cycle later
//   host_wr_valid/addr/data/ready : back-bank write handshake
//   swap_req, frame_start         : swap request, frame boundary pulse
//   swap_done, display_bank       : swap completion pulse, scanned bank
//   ram_addr/we/wdata, ram_rdata  : external RAM port (1-cycle read latency)
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic                  scan_valid,
  output logic [DATA_WIDTH-1:0] scan_data,
  input  logic                  host_wr_valid,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ready,
  input  logic                  swap_req,
  input  logic                  frame_start,
  output logic                  swap_done,
  output logic                  display_bank,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic [1:0]          state_reg, state_next;
  logic                display_bank_reg;
  logic                swap_done_reg;
  logic                scan_valid_reg;
  logic [ADDR_WIDTH:0] last_addr_reg;
  grant_e              grant;

  // Host may only write while no swap is queued or executing, so the back
  // bank contents are frozen from swap_req until the toggle.
  assign host_wr_ready = !reset && !scan_req && (state_reg == ST_IDLE);

  always_comb begin
    grant = GRANT_IDLE;
    if (reset) begin
      grant = GRANT_IDLE;
    end else if (scan_req) begin
      grant = GRANT_SCAN;
    end else if (host_wr_valid && host_wr_ready) begin
      grant = GRANT_HOST;
    end
  end

  // The scan read uses the bank register as it stands in the request cycle;
  // a toggle in the same cycle only lands at the clock edge.
  always_comb begin
    ram_addr = last_addr_reg;
    ram_we   = 1'b0;
    case (grant)
      GRANT_SCAN: ram_addr = {display_bank_reg, scan_addr};
      GRANT_HOST: begin
        ram_addr = {~display_bank_reg, host_wr_addr};
        ram_we   = 1'b1;
      end
      default: ram_addr = reset ? '0 : last_addr_reg;
    endcase
  end

  assign ram_wdata = host_wr_data;

  // Swap FSM. A frame_start that coincides with swap_req is deliberately not
  // honoured: the swap must wait for a full frame boundary after the request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (swap_req) state_next = ST_PENDING;
      ST_PENDING: if (frame_start) state_next = ST_SWAP;
      ST_SWAP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      display_bank_reg <= 1'b0;
      swap_done_reg    <= 1'b0;
      scan_valid_reg   <= 1'b0;
      last_addr_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      last_addr_reg  <= ram_addr;
      scan_valid_reg <= scan_req;
      swap_done_reg  <= (state_reg == ST_SWAP);
      if (state_reg == ST_SWAP) begin
        display_bank_reg <= ~display_bank_reg;
      end
    end
  end

  assign scan_valid   = scan_valid_reg;
  assign scan_data    = ram_rdata;  // RAM already registers the read
  assign swap_done    = swap_done_reg;
  assign display_bank = display_bank_reg;

endmodule
